mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Request front-end for the synchronous single-port 8-bit x 4096 memory. Buffers read/write
//  requests from a valid/ready master in a small FIFO, sequences them onto the memory's
//  readEnable/writeEnable/rw_Addr/writeData pins one at a time, and returns read data over a
//  valid/ready response channel. Sits directly upstream of the memory; owns all its control pins.
// PARAMETERS
//  DATA_SIZE   8     data width; must match memory DATA_SIZE
//  ADDR_WIDTH  12    address width (4096 locations, full range legal, no bounds check)
//  FIFO_DEPTH  4     request FIFO entries; power of two, >= 2
// PORTS
//  clock            in   1            rising-edge clock, shared with memory
//  reset            in   1            synchronous, active-high; shared with memory
//  req_valid        in   1            request present
//  req_ready        out  1            request accepted when valid & ready at clock edge
//  req_write        in   1            1 = write, 0 = read
//  req_addr         in   ADDR_WIDTH   target location
//  req_wdata        in   DATA_SIZE    write data (ignored for reads)
//  rsp_valid        out  1            response present
//  rsp_ready        in   1            response consumed when valid & ready at clock edge
//  rsp_rdata        out  DATA_SIZE    read data (or write data, see CONFIGURATION)
//  mem_read_en      out  1            -> memory readEnable
//  mem_write_en     out  1            -> memory writeEnable
//  mem_addr         out  ADDR_WIDTH   -> memory rw_Addr
//  mem_wdata        out  DATA_SIZE    -> memory writeData
//  mem_rdata        in   DATA_SIZE    <- memory readData (registered, 1-cycle latency)
//  busy             out  1            FIFO non-empty or FSM not IDLE
// BEHAVIOUR
//  - Reset (sync): FIFO emptied, FSM->IDLE, all outputs 0; req_ready forced 0 while reset high.
//    Reset mid-operation discards queued/in-flight requests and any held response.
//  - req_ready = !fifo_full & !reset. Push on req_valid&req_ready; full FIFO stalls the master.
//  - All mem_* outputs registered. mem_read_en and mem_write_en never high together; each high
//    for exactly one cycle (ISSUE); both 0 in every other state.
//  - FSM: IDLE: if FIFO non-empty, pop head, load mem_addr/mem_wdata -> ISSUE.
//    ISSUE: enable high; write -> IDLE; read -> CAPTURE.
//    CAPTURE: mem_rdata valid; register into rsp_rdata, rsp_valid<=1 -> RESP.
//    RESP: hold rsp_valid/rsp_rdata stable until rsp_ready; on handshake rsp_valid<=0 -> IDLE.
//  - Latency (request accepted at edge ending cycle T): enable high in T+2; read rsp_valid
//    from T+4. Throughput: 1 write per 2 cycles, 1 read per 4 cycles with rsp_ready held high.
//  - Ordering strictly FIFO; a read after a write to same address returns the new data.
//  - Push and pop in same cycle on full FIFO: pop frees slot next cycle only (ready uses
//    registered full flag). Push and pop on empty FIFO: entry written, popped next IDLE cycle.
//  - Pointers wrap modulo FIFO_DEPTH; count width $clog2(FIFO_DEPTH)+1.
// CONFIGURATION
//  MEM_ACCESS_CTRL_WRITE_ACK_EN defined: writes also produce a response; ISSUE(write) -> RESP
//    with rsp_rdata = written data, rsp_valid from T+3; master sees one response per request.
//  Not defined: writes produce no response; ISSUE(write) -> IDLE; rsp_* only for reads.
// STRUCTURE
//  Package mem_access_pkg: DATA_SIZE/ADDR_WIDTH defaults, typedef mem_req_t {write, addr,
//  wdata}, typedef enum logic [1:0] ctrl_state_t {IDLE, ISSUE, CAPTURE, RESP}.
//  Sub-module mem_req_fifo: synchronous FIFO of mem_req_t, push/pop/full/empty, sync reset.
//  Top instantiates mem_req_fifo + FSM; no combinational path req_* -> mem_*.
// TESTING (bench instantiates mem_access_ctrl + memory)
//  1 Reset then write 0xA5 @0x123, read @0x123 -> rsp_rdata 0xA5, rsp_valid first in T+4.
//  2 Read @0xFFF after reset, no writes -> rsp_rdata 0x00; never both mem enables high.
//  3 Push 5 reads with rsp_ready=0, FIFO_DEPTH 4 -> req_ready low after 4th; 1st rsp held
//    stable; release rsp_ready -> 5 responses in order, no loss/duplicate.
//  4 Writes 0x11,0x22 @0x000 back-to-back then read @0x000 -> 0x22; writes 2 cycles apart.
//  5 Assert reset in CAPTURE with 2 queued -> next cycle rsp_valid 0, busy 0, enables 0,
//    memory cleared; subsequent read @ earlier written address -> 0x00.
//  6 With MEM_ACCESS_CTRL_WRITE_ACK_EN: write 0x3C -> response 0x3C at T+3; without: none.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types for the memory request front-end.
// Widths here must match the attached single-port memory.
package mem_access_pkg;

  localparam int DATA_SIZE  = 8;
  localparam int ADDR_WIDTH = 12;
  localparam int FIFO_DEPTH = 4;

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_SIZE-1:0]  wdata;
  } mem_req_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP
  } ctrl_state_t;

endpackage

// File: rtl/mem_req_fifo.sv
// Request FIFO of mem_req_t entries.
// Full/empty derive from a registered occupancy count.
module mem_req_fifo
  import mem_access_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     push,
  input  logic     pop,
  input  mem_req_t wr,
  output mem_req_t rd,
  output logic     full,
  output logic     empty
);

  localparam int PW = $clog2(DEPTH);

  mem_req_t        slots [DEPTH];
  logic [PW-1:0]   wp;
  logic [PW-1:0]   rp;
  logic [PW:0]     count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd      = slots[rp];

  always_ff @(posedge clock) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; validity is tracked by count.
  always_ff @(posedge clock) begin
    if (do_push) slots[wp] <= wr;
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Request front-end sequencing a single-port sync memory.
// MEM_ACCESS_CTRL_WRITE_ACK_EN: writes also return a response.
module mem_access_ctrl #(
  parameter int DATA_SIZE  = mem_access_pkg::DATA_SIZE,
  parameter int ADDR_WIDTH = mem_access_pkg::ADDR_WIDTH,
  parameter int FIFO_DEPTH = mem_access_pkg::FIFO_DEPTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_SIZE-1:0]  req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_SIZE-1:0]  rsp_rdata,
  output logic                  mem_read_en,
  output logic                  mem_write_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_SIZE-1:0]  mem_wdata,
  input  logic [DATA_SIZE-1:0]  mem_rdata,
  output logic                  busy
);

  import mem_access_pkg::*;

  ctrl_state_t state;
  mem_req_t    in_req;
  mem_req_t    head;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;

  assign in_req    = '{write: req_write,
                       addr:  req_addr,
                       wdata: req_wdata};
  assign req_ready = ~full & ~reset;
  assign push      = req_valid & req_ready;
  assign pop       = (state == IDLE) & ~empty;
  assign busy      = ~empty | (state != IDLE);

  mem_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wr    (in_req),
    .rd    (head),
    .full  (full),
    .empty (empty)
  );

  // In ISSUE, mem_write_en itself says whether the op is a write.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!empty) begin
            mem_addr     <= head.addr;
            mem_wdata    <= head.wdata;
            mem_read_en  <= ~head.write;
            mem_write_en <= head.write;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          mem_read_en  <= 1'b0;
          mem_write_en <= 1'b0;
          if (mem_write_en) begin
`ifdef MEM_ACCESS_CTRL_WRITE_ACK_EN
            rsp_valid <= 1'b1;
            rsp_rdata <= mem_wdata;
            state     <= RESP;
`else
            state     <= IDLE;
`endif
          end else begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          rsp_rdata <= mem_rdata;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl with a behavioural sync memory.
// Random traffic is scored against an array+queue model.
module tb_mem_access_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [11:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [7:0]  rsp_rdata;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  mem_access_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .mem_read_en  (mem_read_en),
    .mem_write_en (mem_write_en),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .busy         (busy)
  );

  // Memory: registered read, cleared by reset.
  logic [7:0] mem_arr [4096];
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 4096; i++) mem_arr[i] <= 8'h00;
      mem_rdata <= 8'h00;
    end else begin
      if (mem_write_en) mem_arr[mem_addr] <= mem_wdata;
      if (mem_read_en)  mem_rdata <= mem_arr[mem_addr];
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: contents as seen in request order, expected responses.
  logic [7:0] ref_mem [4096];
  logic [7:0] exp_q [$];
  logic       hold_prev = 1'b0;
  logic [7:0] hold_data = '0;

  always @(negedge clock) begin
    if (reset) begin
      for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
      exp_q.delete();
      hold_prev = 1'b0;
    end else begin
      check("en_excl", 32'(mem_read_en & mem_write_en), 0);
      if (hold_prev) begin
        check("rsp_hold_v", 32'(rsp_valid), 1);
        check("rsp_hold_d", 32'(rsp_rdata), 32'(hold_data));
      end
      hold_prev = rsp_valid & ~rsp_ready;
      hold_data = rsp_rdata;
      if (req_valid && req_ready) begin
        if (req_write) begin
          ref_mem[req_addr] = req_wdata;
`ifdef MEM_ACCESS_CTRL_WRITE_ACK_EN
          exp_q.push_back(req_wdata);
`endif
        end else begin
          exp_q.push_back(ref_mem[req_addr]);
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0)
          check("rsp_extra", 32'(rsp_rdata), 32'hFFFF_FFFF);
        else
          check("rsp_data", 32'(rsp_rdata), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Returns #1 after the accepting edge; valid dropped.
  task automatic send(input logic w, input logic [11:0] a,
                      input logic [7:0] d);
    logic ok;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      ok = req_ready;
      @(posedge clock);
      #1;
      if (ok) break;
      if (i == 199) check("send_timeout", 1, 0);
    end
    req_valid = 1'b0;
  endtask

  // n = cycle offset (from accept) of first rsp_valid, 0 if none.
  task automatic wait_rsp(output int n, output logic [7:0] d);
    n = 0;
    d = '0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clock);
      if (rsp_valid) begin
        n = i;
        d = rsp_rdata;
        break;
      end
    end
    @(posedge clock);
    #1;
  endtask

  int         lat;
  logic [7:0] dat;
  int         w1;
  int         w2;
  int         got_n;
  int         acc;
  logic       done;

  initial begin
    step(3);
    @(negedge clock);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_outs", 32'({rsp_valid, busy, mem_read_en, mem_write_en}), 0);
    check("rst_addr", 32'(mem_addr), 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("ready_after_rst", 32'(req_ready), 1);
    step(1);

    // Write then read back, read latency
    send(1'b1, 12'h123, 8'hA5);
    step(6);
    send(1'b0, 12'h123, 8'h00);
    wait_rsp(lat, dat);
    check("t1_lat", lat, 4);
    check("t1_data", 32'(dat), 32'hA5);

    // Untouched top address reads zero
    send(1'b0, 12'hFFF, 8'h00);
    wait_rsp(lat, dat);
    check("t2_lat", lat, 4);
    check("t2_data", 32'(dat), 0);

    // Backpressure: 5 reads stalled on response
    for (int i = 0; i < 5; i++) send(1'b1, 12'h300 + 12'(i), 8'h40 + 8'(i));
    step(12);
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(1'b0, 12'h300 + 12'(i), 8'h00);
    @(negedge clock);
    check("t3_full", 32'(req_ready), 0);
    step(2);
    @(negedge clock);
    check("t3_valid", 32'(rsp_valid), 1);
    check("t3_first", 32'(rsp_rdata), 32'h40);
    step(4);
    @(negedge clock);
    check("t3_still", 32'({rsp_valid, rsp_rdata}), 32'h140);
    @(posedge clock);
    #1;
    rsp_ready = 1'b1;
    got_n = 0;
    for (int i = 0; i < 60 && got_n < 5; i++) begin
      @(negedge clock);
      if (rsp_valid) begin
        check("t3_order", 32'(rsp_rdata), 32'h40 + 32'(got_n));
        got_n++;
      end
    end
    check("t3_count", got_n, 5);
    step(4);
    check("t3_idle", 32'(rsp_valid), 0);

    // Back-to-back writes, issue spacing, last wins
    send(1'b1, 12'h000, 8'h11);
    send(1'b1, 12'h000, 8'h22);
    w1 = 0;
    w2 = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      if (mem_write_en) begin
        if (w1 == 0) w1 = i;
        else if (w2 == 0) w2 = i;
      end
    end
`ifdef MEM_ACCESS_CTRL_WRITE_ACK_EN
    check("t4_gap", w2 - w1, 3);
`else
    check("t4_gap", w2 - w1, 2);
`endif
    step(4);
    send(1'b0, 12'h000, 8'h00);
    wait_rsp(lat, dat);
    check("t4_data", 32'(dat), 32'h22);

    // Reset while first read sits in CAPTURE, two queued
    send(1'b1, 12'h050, 8'h5A);
    step(8);
    send(1'b0, 12'h050, 8'h00);
    send(1'b0, 12'h051, 8'h00);
    send(1'b0, 12'h052, 8'h00);
    reset = 1'b1;
    step(1);
    @(negedge clock);
    check("t5_outs", 32'({rsp_valid, busy, mem_read_en, mem_write_en}), 0);
    check("t5_ready", 32'(req_ready), 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    step(1);
    send(1'b0, 12'h050, 8'h00);
    wait_rsp(lat, dat);
    check("t5_lat", lat, 4);
    check("t5_data", 32'(dat), 0);

    // Write response only when acknowledgement is built in
    send(1'b1, 12'h200, 8'h3C);
    wait_rsp(lat, dat);
`ifdef MEM_ACCESS_CTRL_WRITE_ACK_EN
    check("t6_lat", lat, 3);
    check("t6_data", 32'(dat), 32'h3C);
`else
    check("t6_none", lat, 0);
`endif
    step(4);

    // Random mixed traffic with random response backpressure
    done = 1'b0;
    acc  = 0;
    fork
      begin
        for (int c = 0; c < 1500; c++) begin
          req_valid = ($urandom_range(0, 3) != 0);
          req_write = 1'($urandom_range(0, 1));
          req_addr  = ($urandom_range(0, 3) == 0) ? 12'($urandom)
                                                  : 12'($urandom_range(0, 15));
          req_wdata = 8'($urandom);
          @(negedge clock);
          if (req_valid && req_ready) acc++;
          @(posedge clock);
          #1;
        end
        req_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          rsp_ready = ($urandom_range(0, 2) != 0);
          @(posedge clock);
          #1;
        end
        rsp_ready = 1'b1;
      end
    join
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (!busy && !rsp_valid) break;
    end
    check("rand_accepted", 32'(acc > 100), 1);
    check("drain_idle", 32'({busy, rsp_valid}), 0);
    check("sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
